// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage core: latch enables and flushes, memory-port arbitration, halt drain.
// Optional build macro PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module pipeline_hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dREN,
    input  logic            mem_dWEN,
    input  logic            ex_dREN,
    input  logic [REGW-1:0] ex_wsel,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            id_jump,
    input  logic            id_halt,
    input  logic            ex_branch_taken,
    input  logic            wb_halt,
    output logic            imem_ren,
    output logic            dmem_req,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            halted,
    output logic [CNTW-1:0] stall_cycles,
    output logic [CNTW-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   ret_drain_q, ret_drain_d;
    logic   mem_op;
    logic   mem_pend;
    logic   lu;

    assign mem_op   = mem_dREN | mem_dWEN;
    assign mem_pend = mem_op & ~dhit;
    assign lu       = ex_dREN & (ex_wsel != '0) &
                      ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
    assign halted   = (state_q == HALTED);

    always_comb begin
        state_d     = state_q;
        ret_drain_d = ret_drain_q;
        imem_ren    = 1'b0;
        dmem_req    = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_pend) begin
                    // Data access owns the single port until it completes.
                    dmem_req    = 1'b1;
                    ret_drain_d = 1'b0;
                    state_d     = MEMWAIT;
                end else begin
                    imem_ren = 1'b1;
                    dmem_req = mem_op;
                    if (ihit) begin
                        if (ex_branch_taken) begin
                            pc_en      = 1'b1;
                            ifid_en    = 1'b1;
                            idex_en    = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (lu) begin
                            idex_en    = 1'b1;
                            idex_flush = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                        end else begin
                            pc_en      = 1'b1;
                            ifid_en    = 1'b1;
                            idex_en    = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                            ifid_flush = id_jump;
                            if (id_halt) begin
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end

            DRAIN: begin
                if (wb_halt) begin
                    dmem_req   = mem_op;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    state_d    = HALTED;
                end else if (mem_pend) begin
                    dmem_req    = 1'b1;
                    ret_drain_d = 1'b1;
                    state_d     = MEMWAIT;
                end else if (ex_branch_taken) begin
                    // A taken branch older than the halt cancels the halt.
                    dmem_req   = mem_op;
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = RUN;
                end else begin
                    dmem_req   = mem_op;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end
            end

            MEMWAIT: begin
                dmem_req = 1'b1;
                if (dhit) begin
                    memwb_en    = 1'b1;
                    exmem_en    = 1'b1;
                    exmem_flush = 1'b1;
                    state_d     = ret_drain_q ? DRAIN : RUN;
                end
            end

            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            ret_drain_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNTW-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_en && (state_q != HALTED) && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNTW'(1);
        end
        if ((ifid_flush | idex_flush | exmem_flush) && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage MIPS core.
- Generates per-latch enable/flush and PC enable from cache hits, load-use hazards, branch/jump resolution and halt.
- Arbitrates the single memory port between instruction fetch and data access.
- Sequences halt drain to a sticky halted state.

Parameters:
- REGW, 5, register-select width.
- CNTW, 32, performance counter width.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_dREN  in  1  load in MEM stage
- mem_dWEN  in  1  store in MEM stage
- ex_dREN  in  1  load in EX stage
- ex_wsel  in  REGW  destination register of EX instruction
- id_rs  in  REGW  rs of ID instruction
- id_rt  in  REGW  rt of ID instruction
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  jump resolved in ID
- id_halt  in  1  halt opcode in ID
- ex_branch_taken  in  1  branch resolved taken in EX
- wb_halt  in  1  halt reached WB
- imem_ren  out  1  instruction port request
- dmem_req  out  1  data port request
- pc_en  out  1  PC update
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  bubble insert (valid only with matching _en)
- halted  out  1  core stopped
- stall_cycles  out  CNTW  stall cycle counter
- flush_count  out  CNTW  flush event counter

Behaviour:
- Clocking: single clock CLK; reset nRST asynchronous, active-low.
- States (registered, 2 bits): RUN, MEMWAIT, DRAIN, HALTED. Reset -> RUN.
- Registered side state:
  - ret_drain (1b), reset 0.
  - halted = (state==HALTED).
- Outputs: combinational from state and inputs, no added latency.
- Reset values (state RUN, all inputs 0): pc_en=0, all _en=0, all flushes=0, imem_ren=1, dmem_req=0, halted=0, counters 0.
- Derived signals:
  - mem_op = mem_dREN|mem_dWEN.
  - lu = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
  - adv = ihit in RUN, 1 in DRAIN.
- RUN/DRAIN, mem_op & !dhit:
  - All enables 0, imem_ren=0, dmem_req=1.
  - Next state MEMWAIT; ret_drain <= (state==DRAIN).
- RUN/DRAIN, mem_op & dhit: treat as ready; fall through.
- MEMWAIT:
  - imem_ren=0, dmem_req=1. Until dhit: all enables 0.
  - On dhit: memwb_en=1, exmem_en=1 with exmem_flush=1; front stages held.
  - Next state DRAIN if ret_drain else RUN.
- RUN priority, when adv and no pending mem (highest first):
  1. ex_branch_taken: all en=1, ifid_flush=1, idex_flush=1.
  2. lu: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1.
  3. id_jump: all en=1, ifid_flush=1.
  4. Otherwise all en=1, no flush.
- RUN, !adv (no ihit): all en=0.
- id_halt in RUN with adv and not overridden by rule 1 or 2: latch advances normally, next state DRAIN.
- DRAIN:
  - pc_en=0, imem_ren=0, ifid_en=1 with ifid_flush=1; remaining stages advance every cycle (rules 2/3 ignored).
  - ex_branch_taken in DRAIN (halt killed by branch): flushes as rule 1, pc_en=1, next state RUN.
  - wb_halt -> HALTED.
- HALTED: all en=0, imem_ren=0, dmem_req=0, halted=1; sticky until nRST.
- Simultaneous branch+lu: branch wins; the load-use instruction is flushed.
- Simultaneous wb_halt+mem_op: wb_halt wins.
- Reset mid-MEMWAIT: immediate return to RUN, ret_drain=0, no further dmem_req.

Optional Feature:
- PERF_CNT_EN defined:
  - stall_cycles increments on each cycle with pc_en=0 while state!=HALTED.
  - flush_count increments on each cycle with any flush asserted.
  - Both saturate at all-ones and reset to 0.
- Undefined: both outputs tied 0, no counter flops.

Test Plan:
- Reset, then ihit=1, no hazards -> all en=1, no flush, imem_ren=1, halted=0.
- ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; next cycle (ex_dREN=0) all en=1. ex_wsel=0 -> no stall.
- mem_dREN=1, dhit=0 for 3 cycles then 1 -> MEMWAIT: imem_ren=0, dmem_req=1, en=0 for 3 cycles; dhit cycle memwb_en=1, exmem_flush=1; back to RUN.
- ex_branch_taken=1 together with lu=1 -> ifid_flush=idex_flush=1, pc_en=1; with PERF_CNT_EN, flush_count +1.
- id_halt=1, ihit=1 -> DRAIN; 3 cycles ifid_flush=1, pc_en=0; wb_halt=1 -> halted=1; further ihit ignored; nRST low -> halted=0.
- DRAIN with ex_branch_taken=1 -> state RUN, pc_en=1, ifid_flush=idex_flush=1, halted stays 0.
